// File: rtl/sw_seq_fsm_param.sv
// Parametrised switch-sequence recogniser driving an LED bank.
// Adds stability filtering, dwell timeout and status outputs.
module sw_seq_fsm_param #(
  parameter int W             = 3,
  parameter int MEALY         = 1,
  parameter int STABLE_CYCLES = 0,
  parameter int TIMEOUT       = 0,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     sw,
  output logic [W-1:0]     led,
  output logic [2:0]       state_o,
  output logic             chg,
  output logic             tmo,
  output logic [CNT_W-1:0] trans_cnt
);

  localparam int SCW = (STABLE_CYCLES > 0) ?
                       $clog2(STABLE_CYCLES + 1) : 1;
  localparam int DW  = (TIMEOUT > 0) ?
                       $clog2(TIMEOUT + 1) : 1;

  localparam logic [W-1:0] P_IDLE = '0;
  localparam logic [W-1:0] P_A    = W'(1);
  localparam logic [W-1:0] P_B    = W'(2);
  localparam logic [W-1:0] P_C    = W'(1) << (W - 1);
  localparam logic [W-1:0] P_ALL  = '1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    A    = 3'd1,
    B    = 3'd2,
    C    = 3'd3,
    ALL  = 3'd4
  } st_t;

  st_t            state;
  st_t            nxt;
  st_t            tgt;
  logic           hit;
  logic           stable;
  logic           tmo_hit;
  logic [W-1:0]   sw_q;
  logic [SCW-1:0] stab_cnt;
  logic [DW-1:0]  dwell;

  function automatic logic [W-1:0] pat(input st_t s);
    case (s)
      A:       return P_A;
      B:       return P_B;
      C:       return P_C;
      ALL:     return P_ALL;
      default: return P_IDLE;
    endcase
  endfunction

  always_comb begin
    hit = 1'b0;
    tgt = IDLE;
    case (state)
      IDLE: begin
        if (sw == P_A) begin
          hit = 1'b1;
          tgt = A;
        end else if (sw == P_B) begin
          hit = 1'b1;
          tgt = B;
        end
      end
      A: begin
        if (sw == P_B) begin
          hit = 1'b1;
          tgt = B;
        end
      end
      B: begin
        if (sw == P_C) begin
          hit = 1'b1;
          tgt = C;
        end
      end
      C: begin
        if (sw == P_IDLE) begin
          hit = 1'b1;
          tgt = IDLE;
        end else if (sw == P_A) begin
          hit = 1'b1;
          tgt = A;
        end else if (sw == P_ALL) begin
          hit = 1'b1;
          tgt = ALL;
        end
      end
      ALL: begin
        if (sw == P_C) begin
          hit = 1'b1;
          tgt = C;
        end
      end
      default: ;
    endcase
  end

  assign stable = (STABLE_CYCLES == 0) ||
                  ((sw == sw_q) &&
                   (32'(stab_cnt) >= STABLE_CYCLES - 1));

  // table transitions take priority over the dwell timeout
  assign tmo_hit = (TIMEOUT > 0) && (state != IDLE) &&
                   (state <= ALL) &&
                   (32'(dwell) == TIMEOUT - 1) &&
                   !(stable && hit);

  always_comb begin
    nxt = state;
    if (state > ALL)
      nxt = IDLE;
    else if (stable && hit)
      nxt = tgt;
    else if (tmo_hit)
      nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      sw_q      <= '0;
      stab_cnt  <= '0;
      dwell     <= '0;
      chg       <= 1'b0;
      tmo       <= 1'b0;
      trans_cnt <= '0;
    end else begin
      sw_q <= sw;
      if (sw != sw_q)
        stab_cnt <= '0;
      else if (32'(stab_cnt) < STABLE_CYCLES)
        stab_cnt <= stab_cnt + SCW'(1);
      if (nxt != state || state == IDLE)
        dwell <= '0;
      else
        dwell <= dwell + DW'(1);
      state <= nxt;
      chg   <= (nxt != state);
      tmo   <= tmo_hit;
      if (nxt != state && trans_cnt != '1)
        trans_cnt <= trans_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    led = '0;
    if (rst)
      led = (MEALY != 0 && hit) ? pat(tgt) : pat(state);
  end

  assign state_o = state;

endmodule

// File: tb/tb_sw_seq_fsm_param.sv
// Bench for sw_seq_fsm_param: four configurations, directed
// scenarios plus random traffic against a table-level model.
module tb_sw_seq_fsm_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0] sw_a  [3];
  logic [2:0] led_a [3];
  logic [2:0] st_a  [3];
  logic       chg_a [3];
  logic       tmo_a [3];
  logic [7:0] cnt0, cnt2;
  logic [1:0] cnt1;
  logic [7:0] sw3, led3, cnt3;
  logic [2:0] st3;
  logic       chg3, tmo3;

  int n_run = 0;
  int n_fail = 0;

  sw_seq_fsm_param #(.W(3), .MEALY(0)) u0 (
    .clk(clk), .rst(rst), .sw(sw_a[0]), .led(led_a[0]),
    .state_o(st_a[0]), .chg(chg_a[0]), .tmo(tmo_a[0]),
    .trans_cnt(cnt0));

  sw_seq_fsm_param #(.W(3), .MEALY(1), .CNT_W(2)) u1 (
    .clk(clk), .rst(rst), .sw(sw_a[1]), .led(led_a[1]),
    .state_o(st_a[1]), .chg(chg_a[1]), .tmo(tmo_a[1]),
    .trans_cnt(cnt1));

  sw_seq_fsm_param #(.W(3), .MEALY(0), .STABLE_CYCLES(3),
                     .TIMEOUT(5)) u2 (
    .clk(clk), .rst(rst), .sw(sw_a[2]), .led(led_a[2]),
    .state_o(st_a[2]), .chg(chg_a[2]), .tmo(tmo_a[2]),
    .trans_cnt(cnt2));

  sw_seq_fsm_param #(.W(8), .MEALY(1)) u3 (
    .clk(clk), .rst(rst), .sw(sw3), .led(led3),
    .state_o(st3), .chg(chg3), .tmo(tmo3), .trans_cnt(cnt3));

  typedef struct {
    int st;
    int last;
    int run;
    int age;
    int cnt;
    bit chg;
    bit tmo;
  } m_t;

  m_t m [3];
  int p_s    [3] = '{0, 0, 3};
  int p_t    [3] = '{0, 0, 5};
  int p_cmax [3] = '{255, 3, 255};
  int p_mea  [3] = '{0, 1, 0};

  function automatic logic [7:0] cnt_of(input int i);
    case (i)
      0:       return cnt0;
      1:       return {6'b0, cnt1};
      default: return cnt2;
    endcase
  endfunction

  function automatic int pat(input int st, input int w);
    case (st)
      1:       return 1;
      2:       return 2;
      3:       return 1 << (w - 1);
      4:       return (1 << w) - 1;
      default: return 0;
    endcase
  endfunction

  // spec transition table; -1 = stay
  function automatic int tgt(input int st, input int v,
                             input int w);
    case (st)
      0: return (v == 1) ? 1 : (v == 2) ? 2 : -1;
      1: return (v == 2) ? 2 : -1;
      2: return (v == pat(3, w)) ? 3 : -1;
      3: return (v == 0) ? 0 : (v == 1) ? 1 :
                (v == pat(4, w)) ? 4 : -1;
      4: return (v == pat(3, w)) ? 3 : -1;
      default: return 0;
    endcase
  endfunction

  function automatic m_t m_init();
    m_t x;
    x.st = 0; x.last = 0; x.run = 1; x.age = 0;
    x.cnt = 0; x.chg = 0; x.tmo = 0;
    return x;
  endfunction

  // run = cycles sw has held its value; filter passes after s+1
  function automatic m_t m_step(input m_t x, input int v,
                                input int s, input int t,
                                input int cmax);
    m_t y;
    int g;
    int nx;
    y = x;
    if (v == x.last) y.run = x.run + 1;
    else begin
      y.last = v;
      y.run = 1;
    end
    y.age = x.age + 1;
    g = tgt(x.st, v, 3);
    nx = x.st;
    y.tmo = 0;
    if (g >= 0 && (s == 0 || y.run >= s + 1)) nx = g;
    else if (t > 0 && x.st != 0 && y.age >= t) begin
      nx = 0;
      y.tmo = 1;
    end
    y.chg = (nx != x.st);
    if (y.chg) begin
      y.age = 0;
      if (y.cnt < cmax) y.cnt++;
    end
    y.st = nx;
    return y;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) sw_a[i] = '0;
    sw3 = '0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    sw_a[1] = 3'b001;
    sw3 = 8'h01;
    #3;
    for (int i = 0; i < 3; i++) begin
      n_run++;
      if (st_a[i] !== 3'd0 || led_a[i] !== 3'd0 ||
          chg_a[i] !== 1'b0 || tmo_a[i] !== 1'b0 ||
          cnt_of(i) !== 8'd0) begin
        n_fail++;
        $display("FAIL reset dut%0d st=%0d led=%b chg=%b tmo=%b cnt=%0d exp all 0",
                 i, st_a[i], led_a[i], chg_a[i], tmo_a[i], cnt_of(i));
      end
    end
    n_run++;
    if (led3 !== 8'h00 || st3 !== 3'd0 || cnt3 !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_w8 led=%h st=%0d cnt=%0d exp 0",
               led3, st3, cnt3);
    end
  endtask

  task automatic test_moore_seq();
    int v  [6] = '{1, 2, 4, 7, 4, 0};
    int es [6] = '{1, 2, 3, 4, 3, 0};
    do_reset();
    for (int j = 0; j < 6; j++) begin
      sw_a[0] = 3'(v[j]);
      tick();
      n_run++;
      if (st_a[0] !== 3'(es[j]) || led_a[0] !== 3'(v[j]) ||
          chg_a[0] !== 1'b1 || cnt0 !== 8'(j + 1)) begin
        n_fail++;
        $display("FAIL moore_seq step%0d st=%0d led=%b chg=%b cnt=%0d exp st=%0d led=%b chg=1 cnt=%0d",
                 j, st_a[0], led_a[0], chg_a[0], cnt0,
                 es[j], 3'(v[j]), j + 1);
      end
    end
    tick();
    n_run++;
    if (chg_a[0] !== 1'b0 || cnt0 !== 8'd6) begin
      n_fail++;
      $display("FAIL moore_end chg=%b cnt=%0d exp chg=0 cnt=6",
               chg_a[0], cnt0);
    end
  endtask

  task automatic test_mealy();
    do_reset();
    sw_a[1] = 3'b010;
    #1;
    n_run++;
    if (led_a[1] !== 3'b010 || st_a[1] !== 3'd0) begin
      n_fail++;
      $display("FAIL mealy_preview led=%b st=%0d exp led=010 st=0",
               led_a[1], st_a[1]);
    end
    sw_a[1] = 3'b011;
    #1;
    n_run++;
    if (led_a[1] !== 3'b000) begin
      n_fail++;
      $display("FAIL mealy_nomatch led=%b exp 000", led_a[1]);
    end
    tick();
    n_run++;
    if (st_a[1] !== 3'd0) begin
      n_fail++;
      $display("FAIL mealy_stay st=%0d exp 0", st_a[1]);
    end
    sw_a[1] = 3'b010;
    tick();
    sw_a[1] = 3'b100;
    tick();
    sw_a[1] = 3'b111;
    #1;
    n_run++;
    if (led_a[1] !== 3'b111 || st_a[1] !== 3'd3) begin
      n_fail++;
      $display("FAIL mealy_c_all led=%b st=%0d exp led=111 st=3",
               led_a[1], st_a[1]);
    end
    tick();
    n_run++;
    if (st_a[1] !== 3'd4 || led_a[1] !== 3'b111) begin
      n_fail++;
      $display("FAIL mealy_all st=%0d led=%b exp st=4 led=111",
               st_a[1], led_a[1]);
    end
  endtask

  task automatic chk2(input string nm, input int st,
                      input bit ch, input bit tm);
    n_run++;
    if (st_a[2] !== 3'(st) || chg_a[2] !== ch ||
        tmo_a[2] !== tm || led_a[2] !== 3'(pat(st, 3))) begin
      n_fail++;
      $display("FAIL %s st=%0d chg=%b tmo=%b led=%b exp st=%0d chg=%b tmo=%b",
               nm, st_a[2], chg_a[2], tmo_a[2], led_a[2],
               st, ch, tm);
    end
  endtask

  task automatic test_filter_timeout();
    do_reset();
    sw_a[2] = 3'b001;
    tick();
    tick();
    sw_a[2] = 3'b000;
    for (int j = 0; j < 4; j++) begin
      tick();
      chk2("filter_glitch", 0, 0, 0);
    end
    sw_a[2] = 3'b001;
    for (int j = 0; j < 3; j++) begin
      tick();
      chk2("filter_early", 0, 0, 0);
    end
    tick();
    chk2("filter_enter_a", 1, 1, 0);
    for (int j = 0; j < 4; j++) begin
      tick();
      chk2("dwell_a", 1, 0, 0);
    end
    sw_a[2] = 3'b000;
    tick();
    chk2("timeout_idle", 0, 1, 1);
    tick();
    chk2("timeout_after", 0, 0, 0);
    sw_a[2] = 3'b001;
    for (int j = 0; j < 3; j++) tick();
    tick();
    chk2("reenter_a", 1, 1, 0);
    tick();
    sw_a[2] = 3'b010;
    for (int j = 0; j < 3; j++) begin
      tick();
      chk2("pending_b", 1, 0, 0);
    end
    tick();
    chk2("b_beats_timeout", 2, 1, 0);
  endtask

  task automatic test_sat_reset();
    int v  [6] = '{1, 2, 4, 7, 4, 7};
    int es [6] = '{1, 2, 3, 4, 3, 4};
    int ec [6] = '{1, 2, 3, 3, 3, 3};
    do_reset();
    for (int j = 0; j < 6; j++) begin
      sw_a[1] = 3'(v[j]);
      tick();
      n_run++;
      if (st_a[1] !== 3'(es[j]) || cnt1 !== 2'(ec[j])) begin
        n_fail++;
        $display("FAIL sat_cnt step%0d st=%0d cnt=%0d exp st=%0d cnt=%0d",
                 j, st_a[1], cnt1, es[j], ec[j]);
      end
    end
    #2 rst = 1'b0;
    #1;
    n_run++;
    if (st_a[1] !== 3'd0 || led_a[1] !== 3'd0 ||
        chg_a[1] !== 1'b0 || tmo_a[1] !== 1'b0 ||
        cnt1 !== 2'd0) begin
      n_fail++;
      $display("FAIL async_reset st=%0d led=%b chg=%b cnt=%0d exp all 0",
               st_a[1], led_a[1], chg_a[1], cnt1);
    end
    tick();
    rst = 1'b1;
    sw_a[1] = 3'b001;
    tick();
    n_run++;
    if (st_a[1] !== 3'd1 || led_a[1] !== 3'b001) begin
      n_fail++;
      $display("FAIL post_reset st=%0d led=%b exp st=1 led=001",
               st_a[1], led_a[1]);
    end
  endtask

  task automatic test_wide();
    logic [7:0] v [4] = '{8'h01, 8'h02, 8'h80, 8'hFF};
    do_reset();
    for (int j = 0; j < 4; j++) begin
      sw3 = v[j];
      tick();
      n_run++;
      if (st3 !== 3'(j + 1) || led3 !== v[j] || chg3 !== 1'b1) begin
        n_fail++;
        $display("FAIL wide step%0d st=%0d led=%h chg=%b exp st=%0d led=%h chg=1",
                 j, st3, led3, chg3, j + 1, v[j]);
      end
    end
    n_run++;
    if (cnt3 !== 8'd4 || tmo3 !== 1'b0) begin
      n_fail++;
      $display("FAIL wide_cnt cnt=%0d tmo=%b exp cnt=4 tmo=0",
               cnt3, tmo3);
    end
    do_reset();
    sw3 = 8'h04;
    #1;
    n_run++;
    if (led3 !== 8'h00) begin
      n_fail++;
      $display("FAIL wide_noleds led=%h exp 00", led3);
    end
    tick();
    n_run++;
    if (st3 !== 3'd0 || chg3 !== 1'b0) begin
      n_fail++;
      $display("FAIL wide_nochange st=%0d chg=%b exp st=0 chg=0",
               st3, chg3);
    end
  endtask

  task automatic test_random();
    int pv [5] = '{0, 1, 2, 4, 7};
    int hold [3] = '{0, 0, 0};
    int cur [3] = '{0, 0, 0};
    int g;
    int el;
    do_reset();
    for (int i = 0; i < 3; i++) m[i] = m_init();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (hold[i] == 0) begin
          int r;
          r = int'($urandom_range(0, 9));
          cur[i] = (r < 8) ? pv[r % 5] : int'($urandom_range(0, 7));
          hold[i] = int'($urandom_range(1, 5));
        end
        hold[i]--;
        sw_a[i] = 3'(cur[i]);
      end
      #1;
      for (int i = 0; i < 3; i++) begin
        g = tgt(m[i].st, cur[i], 3);
        el = (p_mea[i] != 0 && g >= 0) ? pat(g, 3) : pat(m[i].st, 3);
        n_run++;
        if (led_a[i] !== 3'(el)) begin
          n_fail++;
          $display("FAIL rand_led dut%0d cyc%0d got=%b exp=%b",
                   i, c, led_a[i], 3'(el));
        end
        m[i] = m_step(m[i], cur[i], p_s[i], p_t[i], p_cmax[i]);
      end
      tick();
      for (int i = 0; i < 3; i++) begin
        n_run++;
        if (st_a[i] !== 3'(m[i].st) || chg_a[i] !== m[i].chg ||
            tmo_a[i] !== m[i].tmo ||
            cnt_of(i) !== 8'(m[i].cnt)) begin
          n_fail++;
          $display("FAIL rand_state dut%0d cyc%0d st=%0d chg=%b tmo=%b cnt=%0d exp st=%0d chg=%b tmo=%b cnt=%0d",
                   i, c, st_a[i], chg_a[i], tmo_a[i], cnt_of(i),
                   m[i].st, m[i].chg, m[i].tmo, m[i].cnt);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) sw_a[i] = '0;
    sw3 = '0;
    test_reset();
    test_moore_seq();
    test_mealy();
    test_filter_timeout();
    test_sat_reset();
    test_wide();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
